// File: rtl/layer2_classify_pkg.sv
// Shared network constants and types for the layer-2 classifier.
// Q8.8 data width, accumulator and product widths, default network
// dimensions and the classifier state enumeration.
package layer2_classify_pkg;

  localparam int unsigned N_HIDDEN = 16;  // hidden activations per inference
  localparam int unsigned N_OUT    = 10;  // output classes
  localparam int unsigned FRAC     = 8;   // fractional bits of Q8.8 data

  localparam int unsigned Q_W      = 16;  // signed Q8.8 word
  localparam int unsigned PROD_W   = 32;  // full Q8.8 x Q8.8 product
  localparam int unsigned ACC_W    = 24;  // per-class accumulator
  localparam int unsigned ADDR_W   = 4;   // weight-2 SRAM row address
  localparam int unsigned CLS_W    = 4;   // class index

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_ARGMAX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/l2_mac_lane.sv
// One signed multiply-shift-accumulate lane of the output layer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : clear accumulator (start of inference)
//   en_i       : perform one MAC this cycle
//   act_i      : signed Q8.8 activation
//   w_i        : signed Q8.8 weight for this lane
//   acc_o      : 24-bit wrapping accumulator
module l2_mac_lane
  import layer2_classify_pkg::*;
#(
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Q_W-1:0]   act_i,
  input  logic [Q_W-1:0]   w_i,
  output logic [ACC_W-1:0] acc_o
);

  logic signed [PROD_W-1:0] prod_c;
  logic        [ACC_W-1:0]  acc_q;

  // Full-precision signed product; operands sign-extended before the multiply.
  assign prod_c = PROD_W'($signed(act_i)) * PROD_W'($signed(w_i));

  // Truncating arithmetic shift back to Q8.8, then 24-bit wrapping add.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod_c >>> SHIFT);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/layer2_classify.sv
// Output layer of the network: accumulates N_HIDDEN activations against a
// weight-2 SRAM row per activation, then picks the arg-max class.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin an inference (only honoured in IDLE)
//   act_valid / act_in  : hidden activation stream, signed Q8.8
//   act_ready           : activation accepted this cycle when valid
//   w2_addr / w2_row    : weight SRAM address, row returned one cycle later
//   busy                : inference in progress
//   done                : one-cycle pulse, class_out/score_out valid
//   class_out/score_out : winning class index and its accumulator value
module layer2_classify #(
  parameter int unsigned N_HIDDEN = layer2_classify_pkg::N_HIDDEN,
  parameter int unsigned N_OUT    = layer2_classify_pkg::N_OUT,
  parameter int unsigned FRAC     = layer2_classify_pkg::FRAC
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         act_valid,
  input  logic [layer2_classify_pkg::Q_W-1:0]          act_in,
  output logic                                         act_ready,
  output logic [layer2_classify_pkg::ADDR_W-1:0]       w2_addr,
  input  logic [layer2_classify_pkg::Q_W*N_OUT-1:0]    w2_row,
  output logic                                         busy,
  output logic                                         done,
  output logic [layer2_classify_pkg::CLS_W-1:0]        class_out,
  output logic [layer2_classify_pkg::ACC_W-1:0]        score_out
);

  import layer2_classify_pkg::*;

  state_t             state_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic [Q_W-1:0]     act_q;
  logic               pend_q;
  logic [CLS_W-1:0]   idx_q;
  logic [CLS_W-1:0]   best_idx_q;
  logic [ACC_W-1:0]   best_q;
  logic [CLS_W-1:0]   class_q;
  logic [ACC_W-1:0]   score_q;
  logic               done_q;
  logic               busy_q;
  logic               ready_q;

  logic               accept_c;
  logic               clr_c;
  logic               take_c;
  logic [ACC_W-1:0]   cur_c;
  logic [ACC_W-1:0]   win_val_c;
  logic [CLS_W-1:0]   win_idx_c;
  logic [ACC_W-1:0]   acc_w [N_OUT];

  assign accept_c = act_valid & ready_q;
  assign clr_c    = (state_q == ST_IDLE) & start;

  // One MAC lane per output class; all lanes share the registered activation.
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    l2_mac_lane #(
      .SHIFT (FRAC)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr_c),
      .en_i  (pend_q),
      .act_i (act_q),
      .w_i   (w2_row[Q_W*k +: Q_W]),
      .acc_o (acc_w[k])
    );
  end

  // Arg-max step: lane 0 always loads, later lanes only on strictly greater.
  always_comb begin
    cur_c = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (idx_q == CLS_W'(k)) cur_c = acc_w[k];
    end
    take_c    = (idx_q == '0) || ($signed(cur_c) > $signed(best_q));
    win_val_c = take_c ? cur_c : best_q;
    win_idx_c = take_c ? idx_q : best_idx_q;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      class_q    <= '0;
      score_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Row for an accepted activation arrives next cycle, so its MAC lags by one.
      pend_q <= accept_c;
      if (accept_c) begin
        act_q <= act_in;
        cnt_q <= cnt_q + ADDR_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept_c && (cnt_q == ADDR_W'(N_HIDDEN - 1))) begin
            state_q <= ST_DRAIN;
            ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          idx_q   <= '0;
          state_q <= ST_ARGMAX;
        end
        ST_ARGMAX: begin
          best_q     <= win_val_c;
          best_idx_q <= win_idx_c;
          idx_q      <= idx_q + CLS_W'(1);
          if (idx_q == CLS_W'(N_OUT - 1)) begin
            class_q <= win_idx_c;
            score_q <= win_val_c;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign act_ready = ready_q;
  assign w2_addr   = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign class_out = class_q;
  assign score_out = score_q;

endmodule

// File: tb/tb_layer2_classify.sv
// Self-checking bench for layer2_classify: SRAM row model, scoreboard of
// expected class/score per inference, latency, handshake and abort checks.
module tb_layer2_classify;

  localparam int NO = 10;
  localparam int NH = 16;

  typedef struct packed {
    logic [3:0]  cls;
    logic [23:0] score;
  } res_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            act_valid;
  logic [15:0]     act_in;
  logic            act_ready;
  logic [3:0]      w2_addr;
  logic [16*NO-1:0] w2_row;
  logic            busy;
  logic            done;
  logic [3:0]      class_out;
  logic [23:0]     score_out;

  logic [16*NO-1:0] wmem [NH];
  logic [15:0]      act_mem [NH];

  res_t exp_q [$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   done_cnt  = 0;
  int   exp_runs  = 0;

  layer2_classify dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .act_valid (act_valid),
    .act_in    (act_in),
    .act_ready (act_ready),
    .w2_addr   (w2_addr),
    .w2_row    (w2_row),
    .busy      (busy),
    .done      (done),
    .class_out (class_out),
    .score_out (score_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight SRAM.
  always @(posedge clk) w2_row <= wmem[w2_addr];

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_weights(input int pat);
    logic [15:0] v;
    for (int r = 0; r < NH; r++) begin
      for (int k = 0; k < NO; k++) begin
        case (pat)
          0:       v = 16'(k * 16);
          1:       v = (k == 3 || k == 7) ? 16'h0080 : 16'h0010;
          2:       v = (k == 5) ? 16'hFF00 : 16'h0100;
          default: v = 16'($urandom);
        endcase
        wmem[r][16*k +: 16] = v;
      end
    end
  endtask

  task automatic set_acts(input int pat);
    for (int j = 0; j < NH; j++) begin
      case (pat)
        0:       act_mem[j] = 16'h0100;
        1:       act_mem[j] = 16'hFF00;
        default: act_mem[j] = 16'($urandom);
      endcase
    end
  endtask

  // Reference: Q8.8 products, truncating shift, 24-bit wrap, lowest-index tie.
  function automatic res_t model();
    logic [23:0]        acc [NO];
    logic signed [15:0] a;
    logic signed [15:0] w;
    logic signed [31:0] p;
    res_t               r;
    for (int k = 0; k < NO; k++) acc[k] = '0;
    for (int j = 0; j < NH; j++) begin
      for (int k = 0; k < NO; k++) begin
        a = act_mem[j];
        w = wmem[j][16*k +: 16];
        p = a * w;
        acc[k] = acc[k] + 24'(p >>> 8);
      end
    end
    r.cls   = '0;
    r.score = acc[0];
    for (int k = 1; k < NO; k++) begin
      if ($signed(acc[k]) > $signed(r.score)) begin
        r.cls   = 4'(k);
        r.score = acc[k];
      end
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_act_ready"}, 32'(act_ready), 32'd0);
    check_eq({pfx, "_busy"},      32'(busy),      32'd0);
    check_eq({pfx, "_done"},      32'(done),      32'd0);
    check_eq({pfx, "_class"},     32'(class_out), 32'd0);
    check_eq({pfx, "_score"},     32'(score_out), 32'd0);
    check_eq({pfx, "_w2_addr"},   32'(w2_addr),   32'd0);
  endtask

  // One inference. gap: toggle act_valid; abort_at: reset after that many
  // accepts; noise: start during ARGMAX and act_valid high outside ACCUM.
  task automatic run_inf(input int gap, input int abort_at, input int noise,
                         input logic [3:0] ecls, input logic [23:0] escore);
    int   acc_n;
    int   n;
    int   guard;
    int   d0;
    bit   seen;
    res_t e;
    if (abort_at == 0) begin
      exp_q.push_back({ecls, escore});
      exp_runs++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_running", 32'(busy), 32'd1);
    acc_n = 0;
    guard = 0;
    while (acc_n < NH && guard < 100) begin
      act_valid = (gap != 0) ? (guard % 2 == 0) : 1'b1;
      act_in    = act_mem[acc_n];
      check_eq("act_ready_accum", 32'(act_ready), 32'd1);
      if (act_valid && act_ready) begin
        check_eq("w2_addr_step", 32'(w2_addr), 32'(acc_n));
        acc_n++;
      end
      guard++;
      @(negedge clk);
      if (abort_at != 0 && acc_n == abort_at) begin
        act_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("abort");
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
        return;
      end
    end
    if (acc_n < NH) check_eq("accept_timeout", 32'(acc_n), 32'(NH));
    act_valid = (noise != 0);
    check_eq("act_ready_drain", 32'(act_ready), 32'd0);
    check_eq("done_early", 32'(done), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      start = (noise != 0) && (n == 4);
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check_eq("done_latency", 32'(n), 32'd12);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("class_out", 32'(class_out), 32'(e.cls));
      check_eq("score_out", 32'(score_out), 32'(e.score));
      @(negedge clk);
      check_eq("done_width", 32'(done), 32'd0);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("class_hold", 32'(class_out), 32'(e.cls));
      check_eq("score_hold", 32'(score_out), 32'(e.score));
    end
    if (noise != 0) begin
      repeat (4) begin
        @(negedge clk);
        check_eq("idle_ready", 32'(act_ready), 32'd0);
        check_eq("idle_addr",  32'(w2_addr),   32'd0);
        check_eq("idle_busy",  32'(busy),      32'd0);
      end
      act_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    res_t r;
    reset     = 1'b1;
    start     = 1'b0;
    act_valid = 1'b0;
    act_in    = '0;
    set_weights(0);
    set_acts(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_act_ready", 32'(act_ready), 32'd0);

    run_inf(0, 0, 0, 4'd9, 24'h000900);
    run_inf(1, 0, 0, 4'd9, 24'h000900);
    set_weights(1);
    run_inf(0, 0, 0, 4'd3, 24'h000800);
    set_weights(2);
    set_acts(1);
    run_inf(0, 0, 0, 4'd5, 24'h001000);
    set_weights(0);
    set_acts(0);
    run_inf(0, 8, 0, 4'd0, 24'h0);
    run_inf(0, 0, 0, 4'd9, 24'h000900);
    run_inf(0, 0, 1, 4'd9, 24'h000900);
    for (int i = 0; i < 3; i++) begin
      set_weights(3);
      set_acts(2);
      r = model();
      run_inf(i == 0 ? 1 : 0, 0, i == 1 ? 1 : 0, r.cls, r.score);
    end

    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(done_cnt), 32'(exp_runs));
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer2_classify.md
LAYER2_CLASSIFY -- requirements
Module: layer2_classify

Interface
REQ-001 SHALL have parameter N_HIDDEN, default 16, meaning hidden activations per inference.
REQ-002 SHALL have parameter N_OUT, default 10, meaning output classes.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of signed Q8.8 data.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin inference; sampled only in IDLE.
REQ-007 SHALL have port act_valid  input  1  sigmoid output act_in valid.
REQ-008 SHALL have port act_in  input  16  signed Q8.8 hidden activation.
REQ-009 SHALL have port act_ready  output  1  block accepts act_in this cycle.
REQ-010 SHALL have port w2_addr  output  4  weight-2 SRAM row address.
REQ-011 SHALL have port w2_row  input  16*N_OUT  SRAM row, one cycle after w2_addr; lane k = bits [16k+15:16k], signed Q8.8.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-014 SHALL have port class_out  output  4  index of winning output.
REQ-015 SHALL have port score_out  output  24  signed accumulator value of winner.

Function
REQ-016 SHALL implement states IDLE, ACCUM, DRAIN, ARGMAX, DONE.
REQ-017 IDLE: start=1 -> clear N_OUT 24-bit accumulators and hidden counter, go ACCUM; otherwise hold.
REQ-018 act_ready SHALL equal (state==ACCUM); accept = act_valid & act_ready; throughput one activation per cycle.
REQ-019 w2_addr SHALL combinationally equal the hidden counter, so the row for accepted activation j arrives the next cycle.
REQ-020 On accept: register act_in, assert MAC-pending for next cycle, increment counter; accept of index N_HIDDEN-1 -> DRAIN.
REQ-021 MAC cycle: for each lane k, acc[k] += sign-extend((act * w2_row[k]) >>> FRAC) to 24 bits; 32-bit product, arithmetic shift, no rounding, 24-bit wrap.
REQ-022 MACs SHALL pipeline with accepts; gaps in act_valid create no errors.
REQ-023 DRAIN: perform final pending MAC, go ARGMAX with compare index 0.
REQ-024 ARGMAX: one lane per cycle, index 0..N_OUT-1; lane 0 loads best; later lane replaces best only if strictly greater (tie -> lowest index).
REQ-025 After lane N_OUT-1: register class_out/score_out, go DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-026 done SHALL rise at the 12th rising edge after the edge accepting the last activation (DRAIN 1 + ARGMAX 10 + DONE entry 1).
REQ-027 class_out/score_out SHALL hold until the next DONE or reset.
REQ-028 start outside IDLE SHALL be ignored; act_valid outside ACCUM SHALL be ignored (no accept, no counter change).

Reset
REQ-029 reset SHALL return state to IDLE from any state, aborting any inference.
REQ-030 Reset values: act_ready=0, busy=0, done=0, class_out=0, score_out=0, w2_addr=0, counter=0, accumulators=0.
REQ-031 An abort SHALL produce no done pulse; a new start after reset SHALL produce a correct result.

Structure
REQ-032 N_HIDDEN, N_OUT, FRAC, the state enumeration and Q8.8 width constants SHALL live in the shared network package.
REQ-033 One sub-module, l2_mac_lane (one signed multiply-shift-accumulate lane), SHALL be instantiated N_OUT times.

Verification
REQ-034 16 activations of 1.0 (0x0100) back-to-back, lane k weights all = k*0x0010 -> class_out=9, score_out=0x000900, done at edge 12 after the last accept.
REQ-035 Same data with act_valid toggled 1-0-1 -> identical result; act_ready low outside ACCUM; w2_addr steps 0..15.
REQ-036 Lanes 3 and 7 equal and maximal -> class_out=3.
REQ-037 Negative data: act=0xFF00 (-1.0), all weights 0x0100 except lane 5 = 0xFF00 -> class_out=5, score_out=+16.0 (0x001000).
REQ-038 reset asserted after the 8th accept -> all outputs at reset values next cycle, no done; a new start then yields the REQ-034 result.
REQ-039 start pulsed during ARGMAX and act_valid held high in IDLE -> no effect; exactly one done per inference.
